// File: rtl/text_sched_pkg.sv
// Shared encodings and glyph geometry for the text cursor scheduler.
package text_sched_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_POP    = 5'b00010,
        ST_DECODE = 5'b00100,
        ST_ISSUE  = 5'b01000,
        ST_WAIT   = 5'b10000
    } state_t;

    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;

    localparam int GLYPH_W   = 5;
    localparam int GLYPH_H   = 7;
    localparam int GLYPH_ADV = 6;
    localparam int LINE_ADV  = 8;

endpackage

// File: rtl/text_char_fifo.sv
// Character buffer: count-based full/empty, registered read data one cycle after pop.
module text_char_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count, count_n;
    logic          push, pop;

    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk)
        if (push) mem[wp] <= wr_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            rd_data  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rd_data <= mem[rp];
                rp      <= rp + 1'b1;
            end
            if (wr_en && full) overflow <= 1'b1;
            count <= count_n;
            full  <= (count_n == (AW+1)'(DEPTH));
            empty <= (count_n == '0);
        end
    end
endmodule

// File: rtl/text_cursor_sched.sv
// Pops characters, tracks the text cursor with wrap/LF/CR, and drives the font engine handshake.
module text_cursor_sched
    import text_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int SCREEN_W   = 240,
    parameter int SCREEN_H   = 240
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_char,
    input  logic                  cfg_we,
    input  logic [DATA_WIDTH-1:0] cfg_x,
    input  logic [DATA_WIDTH-1:0] cfg_y,
    input  logic [DATA_WIDTH-1:0] cfg_size,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  busy,
    output logic                  fe_enable,
    output logic [DATA_WIDTH-1:0] fe_x0,
    output logic [DATA_WIDTH-1:0] fe_y0,
    output logic [DATA_WIDTH-1:0] fe_char,
    output logic [DATA_WIDTH-1:0] fe_size,
    input  logic                  fe_done
);
    localparam int AW = DATA_WIDTH + 4;

    state_t                state;
    logic [DATA_WIDTH-1:0] x_r, y_r, size_r, char_r;
    logic [AW-1:0]         sz_w, line_y, adv_x, wrap_x, wrap_y;

    text_char_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_char),
        .rd_en    (state == ST_POP),
        .rd_data  (char_r),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    assign busy = (state != ST_IDLE) || !empty;

    // Widened math so overshoot past the panel edge is visible before truncation.
    always_comb begin
        sz_w   = AW'(size_r);
        line_y = AW'(y_r) + AW'(LINE_ADV) * sz_w;
        adv_x  = AW'(x_r) + AW'(GLYPH_ADV) * sz_w;
        wrap_x = AW'(x_r);
        wrap_y = AW'(y_r);
        if (wrap_x + AW'(GLYPH_W) * sz_w > AW'(SCREEN_W)) begin
            wrap_x = '0;
            wrap_y = line_y;
        end
        if (wrap_y + AW'(GLYPH_H) * sz_w > AW'(SCREEN_H))
            wrap_y = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            x_r       <= '0;
            y_r       <= '0;
            size_r    <= DATA_WIDTH'(1);
            fe_enable <= 1'b0;
            fe_x0     <= '0;
            fe_y0     <= '0;
            fe_char   <= '0;
            fe_size   <= '0;
        end else begin
            fe_enable <= 1'b0;
            case (state)
                ST_IDLE:   if (!empty) state <= ST_POP;
                ST_POP:    state <= ST_DECODE;
                ST_DECODE: begin
                    if (char_r == DATA_WIDTH'(LF)) begin
                        x_r   <= '0;
                        y_r   <= line_y[DATA_WIDTH-1:0];
                        state <= ST_IDLE;
                    end else if (char_r == DATA_WIDTH'(CR)) begin
                        x_r   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        x_r       <= wrap_x[DATA_WIDTH-1:0];
                        y_r       <= wrap_y[DATA_WIDTH-1:0];
                        fe_x0     <= wrap_x[DATA_WIDTH-1:0];
                        fe_y0     <= wrap_y[DATA_WIDTH-1:0];
                        fe_char   <= char_r;
                        fe_size   <= size_r;
                        fe_enable <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE:  state <= ST_WAIT;
                ST_WAIT: begin
                    if (fe_done) begin
                        x_r   <= adv_x[DATA_WIDTH-1:0];
                        state <= ST_IDLE;
                    end
                end
                default:   state <= ST_IDLE;
            endcase
            // Host configuration overrides any same-edge cursor update; fe_* are untouched.
            if (cfg_we) begin
                x_r    <= cfg_x;
                y_r    <= cfg_y;
                size_r <= (cfg_size == '0) ? DATA_WIDTH'(1) : cfg_size;
            end
        end
    end
endmodule

// File: tb/tb_text_cursor_sched.sv
// Directed table-driven bench for text_cursor_sched with hand sequences for multi-cycle cases.
module tb_text_cursor_sched;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0, cfg_we = 1'b0, fe_done = 1'b0;
    logic [7:0] wr_char = '0, cfg_x = '0, cfg_y = '0, cfg_size = '0;
    logic       full, empty, overflow, busy, fe_enable;
    logic [7:0] fe_x0, fe_y0, fe_char, fe_size;

    int n_cmp = 0;
    int n_bad = 0;
    int en_cnt = 0;

    text_cursor_sched #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .SCREEN_W(240), .SCREEN_H(240)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_char(wr_char),
        .cfg_we(cfg_we), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_size(cfg_size),
        .full(full), .empty(empty), .overflow(overflow), .busy(busy),
        .fe_enable(fe_enable), .fe_x0(fe_x0), .fe_y0(fe_y0), .fe_char(fe_char),
        .fe_size(fe_size), .fe_done(fe_done)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (fe_enable) en_cnt <= en_cnt + 1;

    typedef struct {
        logic [7:0] x, y, sz, ch;
        logic [7:0] ex, ey, es;
    } vec_t;
    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_cfg(input logic [7:0] x, input logic [7:0] y, input logic [7:0] s);
        cfg_we = 1'b1; cfg_x = x; cfg_y = y; cfg_size = s;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_done();
        fe_done = 1'b1;
        tick();
        fe_done = 1'b0;
    endtask

    task automatic wait_enable(input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (fe_enable) seen = 1;
            else tick();
        end
        chk({name, " enable seen"}, seen, 1);
    endtask

    // Writes one char into an idle scheduler, checks exact 3-edge latency and the command,
    // then steps into WAIT.
    task automatic issue(input string name, input logic [7:0] ch,
                         input logic [7:0] ex, input logic [7:0] ey, input logic [7:0] es);
        wr_en = 1'b1; wr_char = ch;
        tick();
        wr_en = 1'b0;
        tick(); tick(); tick();
        chk({name, " fe_enable"}, fe_enable, 1);
        chk({name, " fe_x0"}, fe_x0, ex);
        chk({name, " fe_y0"}, fe_y0, ey);
        chk({name, " fe_char"}, fe_char, ch);
        chk({name, " fe_size"}, fe_size, es);
        tick();
        chk({name, " fe_enable low"}, fe_enable, 0);
    endtask

    initial begin
        tbl[0] = '{x:8'd10,  y:8'd20,  sz:8'd1, ch:8'h41, ex:8'd10,  ey:8'd20,  es:8'd1};
        tbl[1] = '{x:8'd232, y:8'd228, sz:8'd2, ch:8'h41, ex:8'd0,   ey:8'd0,   es:8'd2};
        tbl[2] = '{x:8'd235, y:8'd100, sz:8'd1, ch:8'h5A, ex:8'd235, ey:8'd100, es:8'd1};
        tbl[3] = '{x:8'd236, y:8'd100, sz:8'd1, ch:8'h5A, ex:8'd0,   ey:8'd108, es:8'd1};
        tbl[4] = '{x:8'd0,   y:8'd233, sz:8'd1, ch:8'h30, ex:8'd0,   ey:8'd233, es:8'd1};
        tbl[5] = '{x:8'd0,   y:8'd234, sz:8'd1, ch:8'h31, ex:8'd0,   ey:8'd0,   es:8'd1};
        tbl[6] = '{x:8'd7,   y:8'd9,   sz:8'd0, ch:8'h32, ex:8'd7,   ey:8'd9,   es:8'd1};
        tbl[7] = '{x:8'd200, y:8'd100, sz:8'd8, ch:8'h33, ex:8'd200, ey:8'd100, es:8'd8};

        tick(); tick();
        chk("reset fe_enable", fe_enable, 0);
        chk("reset fe_x0", fe_x0, 0);
        chk("reset fe_size", fe_size, 0);
        chk("reset empty", empty, 1);
        chk("reset full", full, 0);
        chk("reset overflow", overflow, 0);
        chk("reset busy", busy, 0);
        reset = 1'b0;
        tick();

        // Reset cursor defaults: x=0, y=0, size=1.
        issue("default", 8'h21, 8'd0, 8'd0, 8'd1);
        pulse_done();

        for (int i = 0; i < 8; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            do_cfg(tbl[i].x, tbl[i].y, tbl[i].sz);
            issue(nm, tbl[i].ch, tbl[i].ex, tbl[i].ey, tbl[i].es);
            pulse_done();
            chk({nm, " busy after done"}, busy, 0);
        end

        // Advance between consecutive glyphs.
        do_cfg(8'd10, 8'd20, 8'd1);
        issue("adv A", 8'h41, 8'd10, 8'd20, 8'd1);
        pulse_done();
        issue("adv B", 8'h42, 8'd16, 8'd20, 8'd1);
        pulse_done();

        // LF produces no glyph and moves to the next line.
        begin
            int base;
            do_cfg(8'd50, 8'd0, 8'd1);
            base = en_cnt;
            wr_en = 1'b1; wr_char = 8'h0A;
            tick();
            wr_char = 8'h43;
            tick();
            wr_en = 1'b0;
            wait_enable("lf");
            chk("lf fe_char", fe_char, 8'h43);
            chk("lf fe_x0", fe_x0, 8'd0);
            chk("lf fe_y0", fe_y0, 8'd8);
            tick();
            chk("lf pulse count", en_cnt - base, 1);
            pulse_done();
        end

        // Fill past capacity while the engine stalls.
        begin
            int base;
            base = en_cnt;
            for (int i = 0; i < 18; i++) begin
                wr_en = 1'b1; wr_char = 8'h40 + 8'(i);
                tick();
                if (i == 15) chk("ovf not full at 16", full, 0);
                if (i == 16) chk("ovf full at 17", full, 1);
            end
            wr_en = 1'b0;
            chk("ovf overflow", overflow, 1);
            chk("ovf full held", full, 1);
            chk("ovf first char", fe_char, 8'h40);
            pulse_done();
            for (int k = 1; k < 17; k++) begin
                wait_enable("ovf drain");
                chk("ovf drain char", fe_char, 8'h40 + 8'(k));
                tick();
                pulse_done();
            end
            repeat (10) tick();
            chk("ovf pulse total", en_cnt - base, 17);
            chk("ovf empty end", empty, 1);
            chk("ovf busy end", busy, 0);
        end

        // Reset while waiting on the engine.
        begin
            int base;
            do_cfg(8'd30, 8'd30, 8'd2);
            issue("rst pre", 8'h41, 8'd30, 8'd30, 8'd2);
            #2 reset = 1'b1;
            #1;
            chk("rst fe_x0", fe_x0, 0);
            chk("rst fe_y0", fe_y0, 0);
            chk("rst fe_char", fe_char, 0);
            chk("rst fe_size", fe_size, 0);
            chk("rst empty", empty, 1);
            chk("rst overflow", overflow, 0);
            chk("rst busy", busy, 0);
            tick();
            reset = 1'b0;
            base = en_cnt;
            pulse_done();
            tick();
            chk("rst late done busy", busy, 0);
            chk("rst late done no issue", en_cnt - base, 0);
            issue("rst post", 8'h44, 8'd0, 8'd0, 8'd1);
            pulse_done();
        end

        // cfg_we on the same edge as fe_done: cfg wins.
        do_cfg(8'd10, 8'd10, 8'd1);
        issue("col pre", 8'h45, 8'd10, 8'd10, 8'd1);
        cfg_we = 1'b1; cfg_x = 8'd100; cfg_y = 8'd40; cfg_size = 8'd1;
        fe_done = 1'b1;
        tick();
        cfg_we = 1'b0; fe_done = 1'b0;
        issue("col post", 8'h46, 8'd100, 8'd40, 8'd1);
        pulse_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
